seq_div_16x8: RTL

SEQ_DIV_16X8 -- requirements
Module: seq_div_16x8

---
 rtl/seq_div_16x8.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_div_16x8.sv
// ============================================================================
// Module   : seq_div_16x8
// Purpose  : 16/8 unsigned restoring radix-2 sequential divider (16 cycles).
//            Optional divide-by-zero fast path under SEQ_DIV_ZERO_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div_16x8 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [7:0]  b,
   output logic [15:0] q,
   output logic [7:0]  r,
   output logic        busy,
   output logic        done,
   output logic        dz
);

   localparam logic [3:0] c_LAST_ITER = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] work_q,  work_d;
   logic [7:0]  rem_q,   rem_d;
   logic [7:0]  div_q,   div_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [15:0] quo_q,   quo_d;
   logic [7:0]  rmd_q,   rmd_d;

   logic [8:0]  w_pr;
   logic        w_ge;
   logic [7:0]  w_rem_nxt;
   logic [15:0] w_quo_nxt;

   // The partial remainder stays below the divisor, so the 8-bit difference is exact.
   assign w_pr      = {rem_q, work_q[15]};
   assign w_ge      = (w_pr >= {1'b0, div_q});
   assign w_rem_nxt = w_ge ? (w_pr[7:0] - div_q) : w_pr[7:0];
   assign w_quo_nxt = {work_q[14:0], w_ge};

`ifdef SEQ_DIV_ZERO_DET_EN
   logic dz_q, dz_d;
   logic zero_q, zero_d;
`endif

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
`ifdef SEQ_DIV_ZERO_DET_EN
      dz_d    = dz_q;
      zero_d  = zero_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_RUN;
               work_d  = a;
               div_d   = b;
               rem_d   = 8'd0;
               cnt_d   = 4'd0;
`ifdef SEQ_DIV_ZERO_DET_EN
               zero_d  = (b == 8'd0);
`endif
            end
         end
         S_RUN: begin
`ifdef SEQ_DIV_ZERO_DET_EN
            if (zero_q) begin
               state_d = S_DONE;
               quo_d   = 16'hFFFF;
               rmd_d   = work_q[7:0];
               dz_d    = 1'b1;
               zero_d  = 1'b0;
            end else begin
`endif
               work_d = w_quo_nxt;
               rem_d  = w_rem_nxt;
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q == c_LAST_ITER) begin
                  state_d = S_DONE;
                  quo_d   = w_quo_nxt;
                  rmd_d   = w_rem_nxt;
`ifdef SEQ_DIV_ZERO_DET_EN
                  dz_d    = 1'b0;
`endif
               end
`ifdef SEQ_DIV_ZERO_DET_EN
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         work_q  <= 16'd0;
         rem_q   <= 8'd0;
         div_q   <= 8'd0;
         cnt_q   <= 4'd0;
         quo_q   <= 16'd0;
         rmd_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
      end
   end

`ifdef SEQ_DIV_ZERO_DET_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dz_q   <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         dz_q   <= dz_d;
         zero_q <= zero_d;
      end
   end

   assign dz = dz_q;
`else
   assign dz = 1'b0;
`endif

   assign q    = quo_q;
   assign r    = rmd_q;
   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);

endmodule

`default_nettype wire
